// File: rtl/tail_light_sequencer.sv
// Tail-light sequencer: request-driven light FSM with an animation prescaler,
// N-lamp sequential turn sweep per side and a blinking hazard mode.
module tail_light_sequencer #(
    parameter int LEDS_PER_SIDE = 3,
    parameter int TICK_DIV      = 25000000
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     haz_req,
    input  logic                     left_req,
    input  logic                     right_req,
    output logic [LEDS_PER_SIDE-1:0] LEDR_L,
    output logic [LEDS_PER_SIDE-1:0] LEDR_R,
    output logic [2:0]               state_code,
    output logic                     step_tick
);

    localparam int CNT_W  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int STEP_W = $clog2(LEDS_PER_SIDE + 1);

    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(TICK_DIV - 1);
    localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(LEDS_PER_SIDE);

    typedef enum logic [2:0] {
        IDLE       = 3'b000,
        HAZARDS    = 3'b001,
        TURN_LEFT  = 3'b010,
        TURN_RIGHT = 3'b100
    } state_t;

    state_t              state;
    state_t              state_nxt;
    state_t              target;
    logic [STEP_W-1:0]   step;
    logic [STEP_W-1:0]   step_nxt;
    logic [CNT_W-1:0]    count;
    logic [CNT_W-1:0]    count_nxt;
    logic                state_legal;

    // Lowest `s` lamps lit, innermost first.
    function automatic logic [LEDS_PER_SIDE-1:0] thermometer(input logic [STEP_W-1:0] s);
        logic [LEDS_PER_SIDE-1:0] t;
        for (int i = 0; i < LEDS_PER_SIDE; i++) begin
            t[i] = (i < int'(s));
        end
        return t;
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
            state <= IDLE;
            step  <= '0;
        end else begin
            count <= count_nxt;
            state <= state_nxt;
            step  <= step_nxt;
        end
    end

    // Requested mode; both turn requests together mean hazards.
    always_comb begin
        target = IDLE;
        if (haz_req || (left_req && right_req)) begin
            target = HAZARDS;
        end else if (left_req) begin
            target = TURN_LEFT;
        end else if (right_req) begin
            target = TURN_RIGHT;
        end
    end

    always_comb begin
        step_tick   = (count == CNT_LAST);
        count_nxt   = step_tick ? '0 : count + CNT_W'(1);
        state_nxt   = state;
        step_nxt    = step;
        state_legal = (state inside {IDLE, HAZARDS, TURN_LEFT, TURN_RIGHT});

        // Requests only matter on animation steps; a mode change restarts dark.
        if (step_tick) begin
            if (!state_legal) begin
                state_nxt = IDLE;
                step_nxt  = '0;
            end else if (target != state) begin
                state_nxt = target;
                step_nxt  = '0;
            end else begin
                unique case (state)
                    TURN_LEFT, TURN_RIGHT:
                        step_nxt = (step == STEP_LAST) ? '0 : step + STEP_W'(1);
                    HAZARDS:
                        step_nxt = (step == '0) ? STEP_W'(1) : '0;
                    default:
                        step_nxt = '0;
                endcase
            end
        end
    end

    always_comb begin
        LEDR_L     = '0;
        LEDR_R     = '0;
        state_code = state;
        case (state)
            TURN_LEFT:  LEDR_L = thermometer(step);
            TURN_RIGHT: LEDR_R = thermometer(step);
            HAZARDS: begin
                LEDR_L = {LEDS_PER_SIDE{step[0]}};
                LEDR_R = {LEDS_PER_SIDE{step[0]}};
            end
            default: begin
                LEDR_L = '0;
                LEDR_R = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_tail_light_sequencer.sv
// Bench for tail_light_sequencer: directed scenarios plus random requests, checked
// every cycle against a mode/phase reference model for two parameter sets.
module tb_tail_light_sequencer;

    localparam int NA  = 3;
    localparam int TDA = 4;
    localparam int NB  = 1;
    localparam int TDB = 1;

    logic clk = 1'b0;
    logic rst, haz, lreq, rreq;
    logic rst_b, haz_b, l_b, r_b;
    logic [NA-1:0] la, ra;
    logic [NB-1:0] lb, rb;
    logic [2:0] code_a, code_b;
    logic tick_a, tick_b;

    int n_assert = 0;
    int n_fail   = 0;

    // Model: mode 0=idle 1=hazards 2=left 3=right; ph = animation phase.
    int a_cnt = 0, a_mode = 0, a_ph = 0;
    int b_cnt = 0, b_mode = 0, b_ph = 0;

    tail_light_sequencer #(.LEDS_PER_SIDE(NA), .TICK_DIV(TDA)) dut_a (
        .clk(clk), .reset(rst), .haz_req(haz), .left_req(lreq), .right_req(rreq),
        .LEDR_L(la), .LEDR_R(ra), .state_code(code_a), .step_tick(tick_a)
    );

    tail_light_sequencer #(.LEDS_PER_SIDE(NB), .TICK_DIV(TDB)) dut_b (
        .clk(clk), .reset(rst_b), .haz_req(haz_b), .left_req(l_b), .right_req(r_b),
        .LEDR_L(lb), .LEDR_R(rb), .state_code(code_b), .step_tick(tick_b)
    );

    always #5 clk = ~clk;

    function automatic int target_of(input logic h, input logic l, input logic r);
        if (h || (l && r)) return 1;
        if (l) return 2;
        if (r) return 3;
        return 0;
    endfunction

    function automatic int code_of(input int mode);
        case (mode)
            1: return 1;
            2: return 2;
            3: return 4;
            default: return 0;
        endcase
    endfunction

    function automatic int lamps(input int n, input int mode, input int ph, input int side);
        if (mode == side) return (1 << ph) - 1;
        if (mode == 1) return (ph != 0) ? (1 << n) - 1 : 0;
        return 0;
    endfunction

    task automatic model_step(input int n, input int td, input logic rs, input logic h,
                              input logic l, input logic r,
                              inout int cnt, inout int mode, inout int ph);
        int t;
        if (rs) begin
            cnt = 0; mode = 0; ph = 0;
            return;
        end
        if (cnt == td - 1) begin
            t = target_of(h, l, r);
            if (t != mode) begin
                mode = t; ph = 0;
            end else if (mode >= 2) begin
                ph = (ph + 1) % (n + 1);
            end else if (mode == 1) begin
                ph = 1 - ph;
            end
        end
        cnt = (cnt + 1) % td;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step(NA, TDA, rst, haz, lreq, rreq, a_cnt, a_mode, a_ph);
        model_step(NB, TDB, rst_b, haz_b, l_b, r_b, b_cnt, b_mode, b_ph);
        #1;
        check("a_left",  32'(la),     32'(lamps(NA, a_mode, a_ph, 2)));
        check("a_right", 32'(ra),     32'(lamps(NA, a_mode, a_ph, 3)));
        check("a_code",  32'(code_a), 32'(code_of(a_mode)));
        check("a_tick",  32'(tick_a), 32'(a_cnt == TDA - 1));
        check("b_left",  32'(lb),     32'(lamps(NB, b_mode, b_ph, 2)));
        check("b_right", 32'(rb),     32'(lamps(NB, b_mode, b_ph, 3)));
        check("b_code",  32'(code_b), 32'(code_of(b_mode)));
        check("b_tick",  32'(tick_b), 32'(b_cnt == TDB - 1));
    endtask

    initial begin
        rst = 1'b1; haz = 1'b0; lreq = 1'b0; rreq = 1'b0;
        rst_b = 1'b1; haz_b = 1'b0; l_b = 1'b0; r_b = 1'b0;
        repeat (3) cycle();
        check("reset_code", 32'(code_a), 32'd0);
        check("reset_tick", 32'(tick_a), 32'd0);

        // Idle after release: ticks land on the 4th, 8th, 12th cycle.
        rst = 1'b0; rst_b = 1'b0; r_b = 1'b1;
        for (int c = 1; c <= 11; c++) begin
            cycle();
            check("idle_tick_slot", 32'(tick_a), 32'((c % 4) == 3));
        end

        // Left sweep, then hazards requested while the sweep shows 011.
        lreq = 1'b1;
        for (int k = 0; k < 40 && !(a_mode == 2 && a_ph == 2); k++) cycle();
        check("left_at_011", 32'(la), 32'd3);
        haz = 1'b1;
        repeat (16) cycle();
        haz = 1'b0; lreq = 1'b0;
        repeat (8) cycle();

        // Both turn requests together behave as hazards.
        lreq = 1'b1; rreq = 1'b1;
        repeat (12) cycle();
        check("both_req_haz", 32'(code_a), 32'd1);
        lreq = 1'b0; rreq = 1'b0;
        repeat (8) cycle();

        // Short right pulse strictly between ticks is ignored.
        for (int k = 0; k < 8 && a_cnt != 0; k++) cycle();
        rreq = 1'b1;
        repeat (2) cycle();
        rreq = 1'b0;
        repeat (6) cycle();
        check("pulse_ignored", 32'(code_a), 32'd0);

        // Reset in the middle of a right sweep.
        rreq = 1'b1;
        for (int k = 0; k < 40 && !(a_mode == 3 && a_ph == 2); k++) cycle();
        check("right_at_011", 32'(ra), 32'd3);
        rst = 1'b1;
        cycle();
        check("midreset_right", 32'(ra), 32'd0);
        check("midreset_code", 32'(code_a), 32'd0);
        rst = 1'b0;
        repeat (12) cycle();
        rreq = 1'b0;

        // Random requests with occasional resets on both instances.
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 7) == 0) lreq = ~lreq;
            if ($urandom_range(0, 7) == 0) rreq = ~rreq;
            haz   = ($urandom_range(0, 9) == 0);
            rst   = ($urandom_range(0, 59) == 0);
            l_b   = ($urandom_range(0, 3) != 0) ? l_b : ~l_b;
            r_b   = ($urandom_range(0, 3) != 0) ? r_b : ~r_b;
            haz_b = ($urandom_range(0, 11) == 0);
            rst_b = ($urandom_range(0, 79) == 0);
            cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
